// File: rtl/isp_raster_src_8bit_if.sv
// Pixel-stream interface of the raster source: frame control inputs plus the
// registered 8-bit pixel stream with its framing flags.
interface isp_raster_src_8bit_if;
  logic        start;
  logic        continuous;
  logic [1:0]  pat_sel;
  logic        dout_vld;
  logic [7:0]  dout;
  logic        sof;
  logic        eol;
  logic        eof;
  logic        busy;
  logic [15:0] frame_cnt;

  modport master (
    input  start, continuous, pat_sel,
    output dout_vld, dout, sof, eol, eof, busy, frame_cnt
  );

  modport slave (
    output start, continuous, pat_sel,
    input  dout_vld, dout, sof, eol, eof, busy, frame_cnt
  );
endinterface

// File: rtl/isp_raster_src_8bit.sv
// Raster test-pattern source: 8-bit grey pixels with programmable line and
// frame blanking, single-shot or continuous frames.
module isp_raster_src_8bit #(
  parameter logic [11:0] H_DISP  = 12'd480,
  parameter logic [11:0] V_DISP  = 12'd272,
  parameter logic [11:0] H_BLANK = 12'd16,
  parameter logic [15:0] V_BLANK = 16'd64
) (
  input logic                  clk,
  input logic                  rst_n,
  isp_raster_src_8bit_if.master px
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_HBLANK,
    S_VBLANK
  } state_e;

  state_e      state, state_n;
  logic [11:0] col, col_n;
  logic [11:0] row, row_n;
  logic [15:0] blank_cnt, blank_cnt_n;
  logic [1:0]  pat, pat_n;
  logic [15:0] frame_cnt, frame_cnt_n;
  logic [7:0]  pix_n;

  logic        vld_q, sof_q, eol_q, eof_q, busy_q;
  logic [7:0]  dout_q;

  // NOTE: every variable driven here gets a default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    state_n     = state;
    col_n       = col;
    row_n       = row;
    blank_cnt_n = blank_cnt;
    pat_n       = pat;
    frame_cnt_n = frame_cnt;
    unique case (state)
      S_IDLE: begin
        if (px.start) begin
          state_n = S_ACTIVE;
          col_n   = '0;
          row_n   = '0;
          pat_n   = px.pat_sel;
        end
      end
      S_ACTIVE: begin
        if (col == H_DISP - 12'd1) begin
          col_n = '0;
          if (row < V_DISP - 12'd1) begin
            row_n = row + 12'd1;
            if (H_BLANK != 12'd0) begin
              state_n     = S_HBLANK;
              blank_cnt_n = {4'd0, H_BLANK};
            end
          end else begin
            row_n       = '0;
            frame_cnt_n = frame_cnt + 16'd1;
            if (V_BLANK != 16'd0) begin
              state_n     = S_VBLANK;
              blank_cnt_n = V_BLANK;
            end else if (px.continuous) begin
              pat_n = px.pat_sel;
            end else begin
              state_n = S_IDLE;
            end
          end
        end else begin
          col_n = col + 12'd1;
        end
      end
      S_HBLANK: begin
        if (blank_cnt == 16'd1) state_n = S_ACTIVE;
        else                    blank_cnt_n = blank_cnt - 16'd1;
      end
      S_VBLANK: begin
        if (blank_cnt == 16'd1) begin
          if (px.continuous) begin
            state_n = S_ACTIVE;
            pat_n   = px.pat_sel;
          end else begin
            state_n = S_IDLE;
          end
        end else begin
          blank_cnt_n = blank_cnt - 16'd1;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Pixel value for the coordinates the next cycle will present.
  always_comb begin
    pix_n = 8'h00;
    unique case (pat_n)
      2'd0: pix_n = col_n[7:0];
      2'd1: pix_n = row_n[7:0];
      2'd2: pix_n = (col_n[3] ^ row_n[3]) ? 8'hFF : 8'h00;
      2'd3: pix_n = col_n[7:0] + row_n[7:0] + frame_cnt_n[7:0];
      default: pix_n = 8'h00;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      col       <= '0;
      row       <= '0;
      blank_cnt <= '0;
      pat       <= '0;
      frame_cnt <= '0;
      vld_q     <= 1'b0;
      dout_q    <= '0;
      sof_q     <= 1'b0;
      eol_q     <= 1'b0;
      eof_q     <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state     <= state_n;
      col       <= col_n;
      row       <= row_n;
      blank_cnt <= blank_cnt_n;
      pat       <= pat_n;
      frame_cnt <= frame_cnt_n;
      vld_q     <= (state_n == S_ACTIVE);
      dout_q    <= (state_n == S_ACTIVE) ? pix_n : 8'h00;
      sof_q     <= (state_n == S_ACTIVE) && (col_n == 12'd0) && (row_n == 12'd0);
      eol_q     <= (state_n == S_ACTIVE) && (col_n == H_DISP - 12'd1);
      eof_q     <= (state_n == S_ACTIVE) && (col_n == H_DISP - 12'd1)
                   && (row_n == V_DISP - 12'd1);
      busy_q    <= (state_n != S_IDLE);
    end
  end

  assign px.dout_vld  = vld_q;
  assign px.dout      = dout_q;
  assign px.sof       = sof_q;
  assign px.eol       = eol_q;
  assign px.eof       = eof_q;
  assign px.busy      = busy_q;
  assign px.frame_cnt = frame_cnt;

endmodule
